// File: rtl/ebpf_shift_pkg.sv
// Shared types and constants for the eBPF multi-cycle shift sequencer.
//   shift_op_e : request opcode encoding (LSH / RSH / ARSH / reserved)
//   state_e    : sequencer FSM states
//   fmt_result : ALU32 results are zero-extended from bit 31
package ebpf_shift_pkg;

    localparam int DATA_W  = 64;
    localparam int AMT64_W = 6;
    localparam int AMT32_W = 5;

    typedef enum logic [1:0] {
        OP_LSH  = 2'b00,
        OP_RSH  = 2'b01,
        OP_ARSH = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] fmt_result(input logic alu32,
                                                     input logic [DATA_W-1:0] d);
        return alu32 ? {32'b0, d[31:0]} : d;
    endfunction

endpackage

// File: rtl/ebpf_shift_step.sv
// One combinational shift stage of at most STEP bit positions.
//   op     : shift kind (ARSH fills with bit 63, LSH/RSH fill with zeros)
//   data   : value to shift
//   k      : shift distance this cycle, 0..STEP
//   result : shifted value
module ebpf_shift_step
    import ebpf_shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  shift_op_e                 op,
    input  logic [DATA_W-1:0]         data,
    input  logic [$clog2(STEP):0]     k,
    output logic [DATA_W-1:0]         result
);

    always_comb begin
        result = data;
        case (op)
            OP_LSH:  result = data << k;
            OP_RSH:  result = data >> k;
            OP_ARSH: result = $signed(data) >>> k;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/ebpf_shift_sequencer.sv
// Multi-cycle LSH/RSH/ARSH controller for the eBPF ALU. A request is latched
// on accept and shifted at most STEP bits per cycle through ebpf_shift_step,
// then presented on a registered valid/ready response port.
//   clk, rst                     : clock, async active-high reset
//   req_valid/req_ready          : request handshake (ready only in IDLE, rst low)
//   req_op, req_alu32            : opcode and ALU32 select
//   req_a, req_b                 : operand and shift-amount source
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data, rsp_err            : result and reserved-op flag
//   busy                         : an operation is in flight
module ebpf_shift_sequencer
    import ebpf_shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic              req_alu32,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int KW = $clog2(STEP) + 1;

    state_e               state;
    shift_op_e            op_q;
    logic                 alu32_q;
    logic [DATA_W-1:0]    opnd;
    logic [AMT64_W-1:0]   rem;

    shift_op_e            req_op_e;
    logic [AMT64_W-1:0]   amt;
    logic [DATA_W-1:0]    wop;
    logic [KW-1:0]        k;
    logic [AMT64_W-1:0]   rem_next;
    logic [DATA_W-1:0]    shifted;
    logic                 unused_b;

    // Only the low six bits of the amount source are ever meaningful.
    assign unused_b = ^req_b[DATA_W-1:AMT64_W];

    assign req_op_e  = shift_op_e'(req_op);
    assign req_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);

    // Amount and working operand as seen at the accept edge. ALU32 ARSH
    // sign-extends so the 64-bit arithmetic shift produces the right low word.
    always_comb begin
        amt = req_alu32 ? {1'b0, req_b[AMT32_W-1:0]} : req_b[AMT64_W-1:0];
        if (!req_alu32)
            wop = req_a;
        else if (req_op_e == OP_ARSH)
            wop = {{32{req_a[31]}}, req_a[31:0]};
        else
            wop = {32'b0, req_a[31:0]};
    end

    // k = min(rem, STEP); when rem <= STEP it fits in KW bits.
    always_comb begin
        if (rem > AMT64_W'(STEP))
            k = KW'(STEP);
        else
            k = KW'(rem);
        rem_next = rem - AMT64_W'(k);
    end

    ebpf_shift_step #(.STEP(STEP)) u_step (
        .op     (op_q),
        .data   (opnd),
        .k      (k),
        .result (shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_LSH;
            alu32_q   <= 1'b0;
            opnd      <= '0;
            rem       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op_e;
                        alu32_q <= req_alu32;
                        opnd    <= wop;
                        rem     <= amt;
                        if (req_op_e == OP_RSVD) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (amt == '0) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= fmt_result(req_alu32, wop);
                        end else begin
                            state     <= ST_SHIFT;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    opnd <= shifted;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= fmt_result(alu32_q, shifted);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ebpf_shift_sequencer.md
# ebpf_shift_sequencer

Multi-cycle shift controller for the eBPF core ALU. It accepts LSH/RSH/ARSH requests for ALU64 and ALU32 instructions over a valid/ready handshake. It executes each shift iteratively through a narrow per-cycle shift stage, which replaces a full 64-bit barrel shifter on the critical path. It then returns the result on a valid/ready response port to the writeback stage.

## Interface
- STEP, 8, maximum bits shifted per cycle; power of two, 1..32
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE and rst low
- req_op  in  2  00 LSH, 01 RSH (logical), 10 ARSH, 11 reserved
- req_alu32  in  1  1 = ALU32 semantics
- req_a  in  64  operand to shift
- req_b  in  64  shift amount source
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  64  result
- rsp_err  out  1  reserved op was issued
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- Accept occurs when req_valid && req_ready at a clk edge. All request fields are latched at that edge; later changes to the inputs are ignored.
- Amount: ALU64 uses req_b[5:0]; ALU32 uses req_b[4:0]. Upper bits are ignored.
- Working operand, ALU64: req_a.
- Working operand, ALU32 LSH/RSH: {32'b0, req_a[31:0]}.
- Working operand, ALU32 ARSH: req_a[31:0] sign-extended to 64 bits.
- IDLE -> SHIFT on accept with amount != 0 and op != 11.
- IDLE -> DONE on accept with amount == 0. Result is the working operand; for ALU32 the result is the low 32 bits, zero-extended.
- IDLE -> DONE on accept with op == 11. rsp_err = 1, rsp_data = 0.
- In SHIFT, each cycle shifts by k = min(rem, STEP) and sets rem -= k. ARSH fills with bit 63 of the working operand; LSH/RSH fill with zeros.
- SHIFT -> DONE at the edge where rem reaches 0. At that edge rsp_data is loaded; ALU32 results are zero-extended from bit 31.
- DONE: rsp_valid = 1. rsp_data and rsp_err hold stable until rsp_valid && rsp_ready, then DONE -> IDLE.
- No accept in SHIFT or DONE, so the block has one operation outstanding.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, req_ready 0 while rst is high.
- Latency: let N = ceil(amount/STEP), or N = 0 for amount 0 or op 11. rsp_valid rises after edge N+1, counting the accept edge as edge 1. With STEP=8: amount 63 gives N = 8; amount 1 gives N = 1.
- The earliest next accept is the edge after the response handshake. Minimum initiation interval is N+2 cycles.
- Outputs are registered, except req_ready and busy, which decode combinationally from state and rst.
- Reset asserted mid-operation aborts the operation immediately. No response is produced.
- A rsp_ready held high in DONE completes the response in one cycle. rsp_ready in IDLE or SHIFT is ignored.

## Structure
- Package ebpf_shift_pkg holds:
  - shift_op_e (OP_LSH, OP_RSH, OP_ARSH, OP_RSVD)
  - state_e
  - constants DATA_W=64, AMT64_W=6, AMT32_W=5
- Sub-module ebpf_shift_step: combinational one-stage shifter with inputs op, data[63:0] and k[$clog2(STEP):0], output data[63:0]. The sequencer contains the FSM, remaining-amount counter, operand register and result formatting.

## Test plan
- LSH ALU64, a=0x1, b=63 -> rsp_data=0x8000_0000_0000_0000, rsp_valid after edge 9 (STEP=8).
- ARSH ALU64, a=0x8000_0000_0000_0000, b=0x104 (masked to 4) -> 0xF800_0000_0000_0000, rsp_valid after edge 2.
- ARSH ALU32, a=0xDEAD_BEEF_8000_0000, b=36 (masked to 4) -> 0x0000_0000_F800_0000. RSH ALU32 with the same a and b -> 0x0000_0000_0800_0000.
- LSH ALU64, b=0 with a=0x1234 -> 0x1234, rsp_valid after edge 1. Op 11 -> rsp_err=1, rsp_data=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_data stable, req_ready=0, req_valid ignored. Release -> IDLE, then the next request is accepted.
- Assert rst during SHIFT of a b=63 request -> all outputs return to reset values immediately. After rst deasserts, a new request completes correctly.
